// File: rtl/ram_arbiter_pkg.sv
// Shared FSM encodings, default widths and the tie-break helper for ram_arbiter.
// Tie-break mode is selected by RAM_ARB_FIXED_PRIO_EN (fixed priority) or round-robin (default).
package ram_arbiter_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Winner index for the current request pair; prio selects the tie winner.
    function automatic logic pick_winner(input logic r0, input logic r1, input logic prio);
        if (r0 && r1) begin
            return prio;
        end
        return !r0;
    endfunction

endpackage

// File: rtl/ram_arbiter_ram_ip.sv
// Single-port storage for ram_arbiter: registered write, combinational read, no reset.
module ram_ip #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[waddr];

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a shared RAM: IDLE -> ACCESS -> RESP per access.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority to requester 0; otherwise round-robin.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy
);

    state_t                state_reg;
    logic                  idx_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [1:0]            ack_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  busy_reg;

    logic                  win_next;
    logic                  we_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] wdata_next;

    logic                  ram_wr;
    logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef RAM_ARB_FIXED_PRIO_EN
    always_comb begin
        win_next = pick_winner(req0, req1, 1'b0);
    end
`else
    // ptr_reg names the requester that wins the next tie.
    logic ptr_reg;

    always_comb begin
        win_next = pick_winner(req0, req1, ptr_reg);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else if (state_reg == IDLE && (req0 || req1)) begin
            ptr_reg <= !win_next;
        end
    end
`endif

    always_comb begin
        we_next    = win_next ? we1    : we0;
        addr_next  = win_next ? addr1  : addr0;
        wdata_next = win_next ? wdata1 : wdata0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            ack_reg   <= 2'b00;
            rdata_reg <= '0;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ack_reg <= 2'b00;
                    if (req0 || req1) begin
                        idx_reg   <= win_next;
                        we_reg    <= we_next;
                        addr_reg  <= addr_next;
                        wdata_reg <= wdata_next;
                        busy_reg  <= 1'b1;
                        state_reg <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_reg) begin
                        rdata_reg <= ram_rdata;
                    end
                    ack_reg   <= idx_reg ? 2'b10 : 2'b01;
                    state_reg <= RESP;
                end
                RESP: begin
                    ack_reg   <= 2'b00;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    ack_reg   <= 2'b00;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Gating with reset makes a reset in ACCESS abort the pending write.
    assign ram_wr = (state_reg == ACCESS) && we_reg && !reset;

    ram_ip #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .waddr(addr_reg),
        .wdata(wdata_reg),
        .wr   (ram_wr),
        .rdata(ram_rdata)
    );

    assign ack0  = ack_reg[0];
    assign ack1  = ack_reg[1];
    assign rdata = rdata_reg;
    assign busy  = busy_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: timeline model compared every cycle plus literal checks.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1, busy;
    logic [7:0] rdata;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    ram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: an accepted request occupies the next two cycles; effect and ack land in the second.
    int         m_left = 0;
    bit         m_ptr = 0;
    bit         m_idx, m_we;
    logic [3:0] m_addr;
    logic [7:0] m_wd;
    logic [7:0] m_mem [16];
    logic [7:0] m_rdata = 8'h00;
    bit         m_ack0 = 0, m_ack1 = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_left = 0; m_ptr = 0; m_rdata = 8'h00; m_ack0 = 0; m_ack1 = 0;
        end else if (m_left == 0) begin
            m_ack0 = 0; m_ack1 = 0;
            if (req0 || req1) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
                m_idx = !req0;
`else
                m_idx = (req0 && req1) ? m_ptr : !req0;
                m_ptr = !m_idx;
`endif
                m_we   = m_idx ? we1 : we0;
                m_addr = m_idx ? addr1 : addr0;
                m_wd   = m_idx ? wdata1 : wdata0;
                m_left = 2;
            end
        end else if (m_left == 2) begin
            if (m_we) m_mem[m_addr] = m_wd;
            else      m_rdata = m_mem[m_addr];
            m_ack0 = !m_idx; m_ack1 = m_idx;
            m_left = 1;
        end else begin
            m_ack0 = 0; m_ack1 = 0; m_left = 0;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("cyc_ack0", int'(ack0), int'(m_ack0));
            check("cyc_ack1", int'(ack1), int'(m_ack1));
            check("cyc_busy", int'(busy), int'(m_left != 0));
            check("cyc_rdata", int'(rdata), int'(m_rdata));
        end
    end

    // One access; returns negedges until own ack, busy cycles seen, and any foreign ack.
    task automatic access(input bit idx, input bit w, input logic [3:0] a, input logic [7:0] d,
                          output int lat, output int busy_n, output bit other);
        int n = 0;
        busy_n = 0; other = 0; lat = -1;
        if (idx) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
        else     begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
        while (lat < 0 && n < 10) begin
            @(negedge clk);
            n++;
            if (busy) busy_n++;
            if ((idx && ack0) || (!idx && ack1)) other = 1;
            if ((idx && ack1) || (!idx && ack0)) lat = n;
        end
        if (lat < 0) check("ack_timeout", 0, 1);
        req0 = 0; req1 = 0;
        @(negedge clk);
        if (busy) busy_n++;
        $display("access req%0d we=%0d addr=%0h data=%0h lat=%0d rdata=%0h", idx, w, a, d, lat, rdata);
    endtask

    int lat, bn, n;
    bit oth;
    int grants[$];
    int exp_g [4];

    initial begin
        reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        @(posedge clk);
        @(negedge clk);
        check_en = 1;
        check("rst_busy", int'(busy), 0);
        check("rst_ack0", int'(ack0), 0);
        check("rst_rdata", int'(rdata), 0);
        @(negedge clk);
        reset = 0;

        // Write A5 at 3 by requester 0.
        access(0, 1, 4'd3, 8'hA5, lat, bn, oth);
        check("w_lat", lat, 2);
        check("w_busy_cycles", bn, 2);
        check("w_no_ack1", int'(oth), 0);

        // Read 3 by requester 1.
        access(1, 0, 4'd3, 8'h00, lat, bn, oth);
        check("r_lat", lat, 2);
        check("r_rdata", int'(rdata), 8'hA5);
        repeat (3) @(negedge clk);
        check("r_rdata_hold", int'(rdata), 8'hA5);

        // Both requests held continuously.
        grants.delete();
        req0 = 1; we0 = 1; addr0 = 4'd1; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 4'd2; wdata1 = 8'h22;
        n = 0;
        while (grants.size() < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (ack0) grants.push_back(0);
            if (ack1) grants.push_back(1);
        end
        req0 = 0; req1 = 0;
        check("hold_grant_count", grants.size(), 4);
`ifdef RAM_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            check($sformatf("grant%0d", i), (i < grants.size()) ? grants[i] : -1, exp_g[i]);
            $display("grant %0d -> req%0d", i, (i < grants.size()) ? grants[i] : -1);
        end
        @(negedge clk);

        // Lone requester 1 wins whatever the pointer says.
        access(1, 1, 4'd2, 8'h22, lat, bn, oth);
        check("lone1_lat", lat, 2);
        access(1, 0, 4'd2, 8'h00, lat, bn, oth);
        check("lone1_rdata", int'(rdata), 8'h22);
        access(0, 0, 4'd1, 8'h00, lat, bn, oth);
        check("hold_wr_addr1", int'(rdata), 8'h11);

        // Reset during ACCESS aborts a write.
        access(0, 1, 4'd5, 8'h3C, lat, bn, oth);
        req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 8'hFF;
        @(negedge clk);
        check("abort_in_access", int'(busy), 1);
        reset = 1; req0 = 0;
        @(negedge clk);
        check("abort_no_ack0", int'(ack0), 0);
        check("abort_busy", int'(busy), 0);
        reset = 0;
        @(negedge clk);
        check("abort_still_no_ack0", int'(ack0), 0);
        access(0, 0, 4'd5, 8'h00, lat, bn, oth);
        check("abort_read5", int'(rdata), 8'h3C);

        // Top address and wrap to 0.
        access(0, 1, 4'd15, 8'h7E, lat, bn, oth);
        access(1, 0, 4'd15, 8'h00, lat, bn, oth);
        check("top_read15", int'(rdata), 8'h7E);
        access(0, 1, 4'd0, 8'h99, lat, bn, oth);
        check("wrap_write_keeps_rdata", int'(rdata), 8'h7E);
        access(1, 0, 4'd0, 8'h00, lat, bn, oth);
        check("wrap_read0", int'(rdata), 8'h99);

        repeat (2) @(negedge clk);
        check_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
